// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        REFILL = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         CNT_W_DEF = 16;
    localparam int         REFILL_W  = 4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: hold once saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes and a data-cache miss refill FSM that freezes everything.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int REFILL_CYC = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memacc_i,
    input  logic             dcache_hit_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [REFILL_W-1:0] REFILL_LOAD = REFILL_W'(REFILL_CYC - 1);

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [REFILL_W-1:0] refill_q, refill_d;

    logic miss_s;
    logic lu_s;
    logic stall_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic bubble_s;

    assign miss_s  = (state_q == RUN) & exmem_memacc_i & ~dcache_hit_i;
    assign lu_s    = idex_memread_i & (idex_rt_i != REG_ZERO) &
                     ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    // Gated by reset so the pipeline runs freely the instant reset rises.
    assign stall_s = ~rst_i & ((state_q != RUN) | miss_s);

    // miss FSM next-state and refill bookkeeping
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        refill_d  = refill_q;
        case (state_q)
            RUN: begin
                if (miss_s) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b1;
                end else begin
                    state_d   = RUN;
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    state_d   = REFILL;
                    mem_req_d = 1'b0;
                    refill_d  = REFILL_LOAD;
                end else begin
                    state_d   = WAIT;
                end
            end
            REFILL: begin
                if (refill_q == {REFILL_W{1'b0}}) begin
                    state_d  = RUN;
                end else begin
                    refill_d = refill_q - REFILL_W'(1);
                end
            end
            default: begin
                state_d   = RUN;
                mem_req_d = 1'b0;
                refill_d  = {REFILL_W{1'b0}};
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            mem_req_q <= 1'b0;
            refill_q  <= {REFILL_W{1'b0}};
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            refill_q  <= refill_d;
        end
    end

    // Enable priority: freeze, then load-use (its load may feed the branch), then flush.
    always_comb begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b0;
        bubble_s     = 1'b0;
        if (rst_i) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
        end else if (stall_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
        end else if (lu_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            bubble_s     = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_s = 1'b1;
        end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign stall_o       = stall_s;
    assign pc_write_o    = pc_write_s;
    assign ifid_write_o  = ifid_write_s;
    assign ifid_flush_o  = ifid_flush_s;
    assign idex_bubble_o = bubble_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_s),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (bubble_s),
        .cnt_o (bubble_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed plus random stimulus for pipeline_stall_ctrl, checked against a
// cycle-level reference model; a narrow-counter copy exercises saturation.
module tb_pipeline_stall_ctrl;

    localparam int RC = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       idex_memread_i = 1'b0;
    logic [4:0] idex_rt_i = 5'd0;
    logic [4:0] ifid_rs_i = 5'd0;
    logic [4:0] ifid_rt_i = 5'd0;
    logic       branch_taken_i = 1'b0;
    logic       exmem_memacc_i = 1'b0;
    logic       dcache_hit_i = 1'b1;
    logic       mem_ack_i = 1'b0;

    logic        mem_req_o, stall_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
    logic [15:0] stall_cnt_o, bubble_cnt_o;
    logic        s_mem_req, s_stall, s_pc_write, s_ifid_write, s_ifid_flush, s_bubble;
    logic [3:0]  s_stall_cnt, s_bubble_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: outstanding request flag and remaining refill cycles
    bit m_req;
    int m_left;
    bit m_miss;
    int m_scnt, m_bcnt, m_scnt4, m_bcnt4;
    bit e_stall, e_pcw, e_ifw, e_fl, e_bub;

    always #5 clk_i = ~clk_i;

    pipeline_stall_ctrl #(.CNT_W(16), .REFILL_CYC(RC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .branch_taken_i(branch_taken_i), .exmem_memacc_i(exmem_memacc_i),
        .dcache_hit_i(dcache_hit_i), .mem_ack_i(mem_ack_i),
        .mem_req_o(mem_req_o), .stall_o(stall_o), .pc_write_o(pc_write_o),
        .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .stall_cnt_o(stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    pipeline_stall_ctrl #(.CNT_W(4), .REFILL_CYC(RC)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .branch_taken_i(branch_taken_i), .exmem_memacc_i(exmem_memacc_i),
        .dcache_hit_i(dcache_hit_i), .mem_ack_i(mem_ack_i),
        .mem_req_o(s_mem_req), .stall_o(s_stall), .pc_write_o(s_pc_write),
        .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
        .idex_bubble_o(s_bubble), .stall_cnt_o(s_stall_cnt),
        .bubble_cnt_o(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_eval();
        bit active, lu;
        active = m_req || (m_left > 0);
        m_miss = !active && exmem_memacc_i && !dcache_hit_i;
        lu = idex_memread_i && (idex_rt_i != 5'd0) &&
             ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
        e_stall = active || m_miss;
        e_pcw = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; e_bub = 1'b0;
        if (e_stall) begin
            e_pcw = 1'b0; e_ifw = 1'b0;
        end else if (lu) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_bub = 1'b1;
        end else if (branch_taken_i) begin
            e_fl = 1'b1;
        end
    endtask

    task automatic model_step();
        if (e_stall) begin
            m_scnt  = sat_inc(m_scnt, 16'hFFFF);
            m_scnt4 = sat_inc(m_scnt4, 15);
        end
        if (e_bub) begin
            m_bcnt  = sat_inc(m_bcnt, 16'hFFFF);
            m_bcnt4 = sat_inc(m_bcnt4, 15);
        end
        if (m_miss) begin
            m_req = 1'b1;
        end else if (m_req && mem_ack_i) begin
            m_req  = 1'b0;
            m_left = RC;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    task automatic cyc();
        #1;
        model_eval();
        chk("stall", stall_o, e_stall);
        chk("mem_req", mem_req_o, m_req);
        chk("pc_write", pc_write_o, e_pcw);
        chk("ifid_write", ifid_write_o, e_ifw);
        chk("ifid_flush", ifid_flush_o, e_fl);
        chk("idex_bubble", idex_bubble_o, e_bub);
        chk("stall_cnt", stall_cnt_o, m_scnt);
        chk("bubble_cnt", bubble_cnt_o, m_bcnt);
        chk("s_stall", s_stall, e_stall);
        chk("s_flush", s_ifid_flush, e_fl);
        chk("s_bubble", s_bubble, e_bub);
        chk("s_wr", {s_mem_req, s_pc_write, s_ifid_write}, {m_req, e_pcw, e_ifw});
        chk("s_stall_cnt", s_stall_cnt, m_scnt4);
        chk("s_bubble_cnt", s_bubble_cnt, m_bcnt4);
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_pcw_ifw", {pc_write_o, ifid_write_o}, 2'b11);
        chk("rst_fl_bub", {ifid_flush_o, idex_bubble_o}, 2'b00);
        chk("rst_cnts", {stall_cnt_o, bubble_cnt_o}, 32'd0);
        chk("rst_s_cnts", {s_stall_cnt, s_bubble_cnt}, 8'd0);
        m_req = 1'b0; m_left = 0;
        m_scnt = 0; m_bcnt = 0; m_scnt4 = 0; m_bcnt4 = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        do_reset();
        cyc();

        // load-use on rs
        idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8; ifid_rt_i = 5'd3;
        cyc();
        idex_memread_i = 1'b0;
        cyc();
        chk("lu_bubble_cnt", bubble_cnt_o, 16'd1);

        // load to $0 never bubbles
        idex_memread_i = 1'b1; idex_rt_i = 5'd0; ifid_rs_i = 5'd4; ifid_rt_i = 5'd0;
        cyc();
        idex_memread_i = 1'b0;

        // miss with ack five cycles after the request rises
        do_reset();
        exmem_memacc_i = 1'b1; dcache_hit_i = 1'b0;
        cyc();
        dcache_hit_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        mem_ack_i = 1'b1;
        cyc();
        mem_ack_i = 1'b0;
        for (int i = 0; i < RC + 1; i++) cyc();
        chk("miss_stall_cnt", stall_cnt_o, 16'd8);
        exmem_memacc_i = 1'b0;

        // taken branch held across a miss: flush only after release
        branch_taken_i = 1'b1; exmem_memacc_i = 1'b1; dcache_hit_i = 1'b0;
        cyc();
        dcache_hit_i = 1'b1; mem_ack_i = 1'b1;
        cyc();
        mem_ack_i = 1'b0;
        for (int i = 0; i < RC; i++) cyc();
        #1;
        chk("br_after_miss_flush", {ifid_flush_o, ifid_write_o}, 2'b11);
        cyc();
        branch_taken_i = 1'b0; exmem_memacc_i = 1'b0;

        // load-use and branch together: bubble first, flush next cycle
        idex_memread_i = 1'b1; idex_rt_i = 5'd9; ifid_rs_i = 5'd1; ifid_rt_i = 5'd9;
        branch_taken_i = 1'b1;
        cyc();
        idex_memread_i = 1'b0;
        cyc();
        branch_taken_i = 1'b0;

        // reset while waiting for memory
        exmem_memacc_i = 1'b1; dcache_hit_i = 1'b0;
        cyc();
        cyc();
        chk("wait_req_high", mem_req_o, 1'b1);
        do_reset();
        dcache_hit_i = 1'b1;
        cyc();
        cyc();

        // random traffic; the narrow copy saturates its counters
        for (int i = 0; i < 500; i++) begin
            idex_memread_i = 1'($urandom_range(0, 1));
            idex_rt_i      = 5'($urandom_range(0, 3));
            ifid_rs_i      = 5'($urandom_range(0, 3));
            ifid_rt_i      = 5'($urandom_range(0, 3));
            branch_taken_i = ($urandom_range(0, 3) == 0);
            exmem_memacc_i = 1'($urandom_range(0, 1));
            dcache_hit_i   = ($urandom_range(0, 9) < 7);
            mem_ack_i      = ($urandom_range(0, 9) < 3);
            cyc();
        end
        chk("sat_s_stall_cnt", s_stall_cnt, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
